// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage.
//   NOP_INST          : word presented to decode when nothing is buffered
//   RESET_PC_DEFAULT  : default first fetch address after reset
//   credit_width()    : width of an occupancy counter for a queue of given depth
//   word_align()      : clears the byte-offset bits of an address
//   inflight_t        : outstanding request record (fetch address + kill flag)
//   prefetch_t        : buffered instruction record (pc + word)
package fetch_unit_pkg;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          INFLIGHT_W       = 33;
    localparam int          PREFETCH_W       = 64;

    typedef struct packed {
        logic [31:0] pc;
        logic        kill;
    } inflight_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } prefetch_t;

    // Counter must represent 0..depth inclusive.
    function automatic int credit_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_checker.sv
// Protocol checks for fetch_unit, kept apart from the datapath.
//   resp_valid/inflight_empty : every response must have an outstanding request
//   pf_push/pf_full           : prefetch buffer never overflows
//   if_push/if_full           : in-flight queue never overflows
//   req_*                     : request stays stable until accepted
module fetch_unit_checker #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        resp_valid,
    input  logic        inflight_empty,
    input  logic        pf_push,
    input  logic        pf_full,
    input  logic        if_push,
    input  logic        if_full,
    input  logic        req_valid,
    input  logic        req_ready,
    input  logic [31:0] req_addr
);

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("fetch_unit: FIFO_DEPTH must be a power of two and at least 2");
    end

    a_resp_has_owner: assert property (@(posedge clk) disable iff (!rst_n)
        resp_valid |-> !inflight_empty);

    a_pf_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        pf_push |-> !pf_full);

    a_if_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        if_push |-> !if_full);

    a_req_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (req_valid && !req_ready) |=> (req_valid && $stable(req_addr)));

endmodule

// File: rtl/fetch_unit_sync_fifo_flush.sv
// sync_fifo_flush: parameterised synchronous FIFO with occupancy count,
// single-cycle flush, and a "mark all" strobe that ORs MARK_MASK into every
// stored entry (including one written in the same cycle).
//   clk, rst_n       : clock, asynchronous active-low reset
//   flush            : empties the FIFO on the next edge; wins over push/pop
//   mark_all         : sets MARK_MASK bits in every entry in place
//   push/wdata       : write side (ignored when full)
//   pop/rdata        : read side, rdata is the current head (ignored when empty)
//   count/empty/full : occupancy status
module sync_fifo_flush #(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] MARK_MASK = {WIDTH{1'b0}}
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     mark_all,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign empty     = (count_r == {CW{1'b0}});
    assign full      = (count_r == CW'(DEPTH));
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign rdata     = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Pointer and occupancy bookkeeping; flush resets to empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            wr_ptr_r <= push_ok_s ? (wr_ptr_r + AW'(1'b1)) : wr_ptr_r;
            rd_ptr_r <= pop_ok_s  ? (rd_ptr_r + AW'(1'b1)) : rd_ptr_r;
            count_r  <= count_r + CW'(push_ok_s) - CW'(pop_ok_s);
        end
    end

    // Storage: write the pushed entry, and apply the mark mask everywhere.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (push_ok_s && !flush && (wr_ptr_r == AW'(i))) begin
                    mem_r[i] <= mark_all ? (wdata | MARK_MASK) : wdata;
                end else if (mark_all) begin
                    mem_r[i] <= mem_r[i] | MARK_MASK;
                end else begin
                    mem_r[i] <= mem_r[i];
                end
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues in-order word fetches to instruction
// memory, buffers returned words with their PCs and hands them to decode.
// A redirect flushes the buffer and marks every outstanding request killed
// so its response is dropped on arrival.
//   clk, reset                : clock, asynchronous active-low reset
//   imem_req_valid/ready/addr : fetch request channel (valid/addr registered)
//   imem_resp_valid/data      : in-order responses, no backpressure
//   jump_flag/jump_target     : redirect pulse and target (byte bits ignored)
//   inst_valid/ready          : decode handshake
//   inst/inst_pc              : head word and its PC (NOP / 0 when empty)
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        jump_flag,
    input  logic [31:0] jump_target,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    localparam int CNT_W = credit_width(FIFO_DEPTH);
    localparam int OCC_W = CNT_W + 1;

    // Request-side state. fetch_pc_r is the address the next newly loaded
    // request will use; it advances when that request is loaded.
    logic        req_valid_r, req_valid_d;
    logic [31:0] req_addr_r,  req_addr_d;
    logic [31:0] fetch_pc_r,  fetch_pc_d;
    logic        pending_kill_r, pending_kill_d;

    logic [31:0] jump_pc_s;
    logic [31:0] eff_pc_s;
    logic        req_fire_s;
    logic        req_held_s;
    logic        load_req_s;

    inflight_t         if_wdata_s;
    inflight_t         if_head_s;
    logic [CNT_W-1:0]  if_count_s;
    logic              if_empty_s;
    logic              if_full_s;
    logic              if_pop_s;

    prefetch_t         pf_wdata_s;
    prefetch_t         pf_head_s;
    logic [CNT_W-1:0]  pf_count_s;
    logic              pf_empty_s;
    logic              pf_full_s;
    logic              pf_push_s;
    logic              pf_pop_s;

    logic [CNT_W-1:0]  pf_count_next_s;
    logic [CNT_W-1:0]  if_count_next_s;
    logic [OCC_W-1:0]  occ_next_s;

    assign jump_pc_s  = word_align(jump_target);
    assign eff_pc_s   = jump_flag ? jump_pc_s : fetch_pc_r;
    assign req_fire_s = req_valid_r && imem_req_ready;
    assign req_held_s = req_valid_r && !imem_req_ready;

    // A request accepted during a redirect, or one that was pending when an
    // earlier redirect happened, is born killed.
    assign if_wdata_s = '{pc: req_addr_r, kill: (pending_kill_r || jump_flag)};

    // Responses retire the in-flight head; killed ones and any arriving in
    // the redirect cycle are dropped.
    assign if_pop_s   = imem_resp_valid && !if_empty_s;
    assign pf_push_s  = if_pop_s && !if_head_s.kill && !jump_flag;
    assign pf_wdata_s = '{pc: if_head_s.pc, data: imem_resp_data};
    assign pf_pop_s   = !pf_empty_s && inst_ready;

    // Credit accounting on post-edge occupancy: buffered + outstanding +
    // a request still held on the channel must stay within FIFO_DEPTH.
    always_comb begin
        pf_count_next_s = pf_count_s;
        if (jump_flag) begin
            pf_count_next_s = {CNT_W{1'b0}};
        end else begin
            pf_count_next_s = pf_count_s + CNT_W'(pf_push_s) - CNT_W'(pf_pop_s);
        end
        if_count_next_s = if_count_s + CNT_W'(req_fire_s) - CNT_W'(if_pop_s);
        occ_next_s      = OCC_W'(pf_count_next_s) + OCC_W'(if_count_next_s)
                        + OCC_W'(req_held_s);
        load_req_s      = (occ_next_s < OCC_W'(FIFO_DEPTH));
    end

    // Next request / PC selection.
    always_comb begin
        req_valid_d    = 1'b0;
        req_addr_d     = req_addr_r;
        pending_kill_d = 1'b0;
        fetch_pc_d     = eff_pc_s;
        if (req_held_s) begin
            req_valid_d    = 1'b1;
            pending_kill_d = pending_kill_r || jump_flag;
        end else if (load_req_s) begin
            req_valid_d    = 1'b1;
            req_addr_d     = eff_pc_s;
            fetch_pc_d     = eff_pc_s + 32'd4;
        end else begin
            req_valid_d    = 1'b0;
        end
    end

    // Request channel and PC registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_valid_r    <= 1'b0;
            req_addr_r     <= RESET_PC;
            fetch_pc_r     <= RESET_PC;
            pending_kill_r <= 1'b0;
        end else begin
            req_valid_r    <= req_valid_d;
            req_addr_r     <= req_addr_d;
            fetch_pc_r     <= fetch_pc_d;
            pending_kill_r <= pending_kill_d;
        end
    end

    sync_fifo_flush #(
        .WIDTH     (INFLIGHT_W),
        .DEPTH     (FIFO_DEPTH),
        .MARK_MASK (33'h0_0000_0001)
    ) u_inflight (
        .clk      (clk),
        .rst_n    (reset),
        .flush    (1'b0),
        .mark_all (jump_flag),
        .push     (req_fire_s),
        .wdata    (if_wdata_s),
        .pop      (if_pop_s),
        .rdata    (if_head_s),
        .count    (if_count_s),
        .empty    (if_empty_s),
        .full     (if_full_s)
    );

    sync_fifo_flush #(
        .WIDTH     (PREFETCH_W),
        .DEPTH     (FIFO_DEPTH),
        .MARK_MASK (64'h0000_0000_0000_0000)
    ) u_prefetch (
        .clk      (clk),
        .rst_n    (reset),
        .flush    (jump_flag),
        .mark_all (1'b0),
        .push     (pf_push_s),
        .wdata    (pf_wdata_s),
        .pop      (pf_pop_s),
        .rdata    (pf_head_s),
        .count    (pf_count_s),
        .empty    (pf_empty_s),
        .full     (pf_full_s)
    );

    fetch_unit_checker #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_checker (
        .clk            (clk),
        .rst_n          (reset),
        .resp_valid     (imem_resp_valid),
        .inflight_empty (if_empty_s),
        .pf_push        (pf_push_s),
        .pf_full        (pf_full_s),
        .if_push        (req_fire_s),
        .if_full        (if_full_s),
        .req_valid      (req_valid_r),
        .req_ready      (imem_req_ready),
        .req_addr       (req_addr_r)
    );

    assign imem_req_valid = req_valid_r;
    assign imem_req_addr  = req_addr_r;
    assign inst_valid     = !pf_empty_s;
    assign inst           = pf_empty_s ? NOP_INST : pf_head_s.data;
    assign inst_pc        = pf_empty_s ? 32'h0000_0000 : pf_head_s.pc;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        jump_flag;
    logic [31:0] jump_target;
    logic        inst_valid, inst_ready;
    logic [31:0] inst, inst_pc;

    logic        w_req_valid;
    logic [31:0] w_req_addr;
    logic        w_resp_valid;
    logic [31:0] w_resp_data;
    logic        w_inst_valid;
    logic [31:0] w_inst, w_inst_pc;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int lat = 1;
    int hs_count = 0;
    int first_hs = -1;
    int first_iv = -1;

    logic [31:0] mq_addr[$];
    int          mq_due[$];
    logic [31:0] got[$];
    logic [31:0] got_d[$];
    logic [31:0] got_w[$];

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .jump_flag(jump_flag), .jump_target(jump_target),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(4)) dut_w (
        .clk(clk), .reset(reset),
        .imem_req_valid(w_req_valid), .imem_req_ready(1'b1),
        .imem_req_addr(w_req_addr),
        .imem_resp_valid(w_resp_valid), .imem_resp_data(w_resp_data),
        .jump_flag(1'b0), .jump_target(32'h0000_0000),
        .inst_valid(w_inst_valid), .inst_ready(1'b1),
        .inst(w_inst), .inst_pc(w_inst_pc)
    );

    function automatic logic [31:0] enc(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes before the edge, update memory models after.
    task automatic step();
        logic        hs;
        logic [31:0] a;
        logic        hw;
        logic [31:0] aw;
        hs = imem_req_valid && imem_req_ready;
        a  = imem_req_addr;
        if (hs && first_hs < 0) first_hs = cycle;
        if (inst_valid && inst_ready) begin
            got.push_back(inst_pc);
            got_d.push_back(inst);
        end
        hw = w_req_valid;
        aw = w_req_addr;
        if (w_inst_valid) got_w.push_back(w_inst_pc);
        @(posedge clk);
        #1;
        cycle++;
        if (hs) begin
            hs_count++;
            mq_addr.push_back(a);
            mq_due.push_back(cycle + lat - 1);
        end
        if (mq_due.size() > 0 && mq_due[0] <= cycle) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = enc(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0000_0000;
        end
        w_resp_valid = hw;
        w_resp_data  = enc(aw);
        if (inst_valid && first_iv < 0) first_iv = cycle;
    endtask

    task automatic clear_models();
        mq_addr.delete();
        mq_due.delete();
        got.delete();
        got_d.delete();
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0000_0000;
        w_resp_valid    = 1'b0;
        w_resp_data     = 32'h0000_0000;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clear_models();
        step();
        step();
        clear_models();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset          = 1'b0;
        imem_req_ready = 1'b0;
        jump_flag      = 1'b0;
        jump_target    = 32'h0000_0000;
        inst_ready     = 1'b0;
        clear_models();
        repeat (3) step();

        // Reset state
        check("rst_req_valid", 32'(imem_req_valid), 32'h0);
        check("rst_req_addr", imem_req_addr, 32'h0000_0000);
        check("rst_inst_valid", 32'(inst_valid), 32'h0);
        check("rst_inst", inst, 32'h0000_0013);
        check("rst_inst_pc", inst_pc, 32'h0000_0000);
        check("rst_w_req_addr", w_req_addr, 32'hFFFF_FFF8);

        // Streaming with 1-cycle memory
        lat = 1; imem_req_ready = 1'b1; inst_ready = 1'b1;
        first_hs = -1; first_iv = -1;
        reset = 1'b1;
        step();
        check("t1_first_req_valid", 32'(imem_req_valid), 32'h1);
        check("t1_first_req_addr", imem_req_addr, 32'h0000_0000);
        repeat (20) step();
        check("t1_latency", 32'(first_iv - first_hs), 32'd2);
        check("t1_throughput", 32'(got.size()), 32'd18);
        for (int i = 0; i < 8; i++) begin
            check("t1_pc", (got.size() > i) ? got[i] : 32'hDEAD_BEEF, 32'(4 * i));
            check("t1_word", (got_d.size() > i) ? got_d[i] : 32'hDEAD_BEEF, enc(32'(4 * i)));
        end
        check("t5_wrap_pc0", (got_w.size() > 0) ? got_w[0] : 32'hDEAD_BEEF, 32'hFFFF_FFF8);
        check("t5_wrap_pc1", (got_w.size() > 1) ? got_w[1] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
        check("t5_wrap_pc2", (got_w.size() > 2) ? got_w[2] : 32'hDEAD_BEEF, 32'h0000_0000);

        // Decode stall: exactly FIFO_DEPTH requests, then drain in order
        do_reset();
        lat = 1; imem_req_ready = 1'b1; inst_ready = 1'b0; hs_count = 0;
        reset = 1'b1;
        repeat (20) step();
        check("t2_req_count", 32'(hs_count), 32'd4);
        check("t2_req_valid_low", 32'(imem_req_valid), 32'h0);
        check("t2_inst_valid", 32'(inst_valid), 32'h1);
        check("t2_head_pc", inst_pc, 32'h0000_0000);
        inst_ready = 1'b1;
        repeat (8) step();
        for (int i = 0; i < 5; i++) begin
            check("t2_pc", (got.size() > i) ? got[i] : 32'hDEAD_BEEF, 32'(4 * i));
        end

        // Redirect while a request is held on the channel
        do_reset();
        lat = 1; imem_req_ready = 1'b1; inst_ready = 1'b1;
        reset = 1'b1;
        for (int k = 0; k < 10 && !(imem_req_valid && imem_req_addr == 32'h8); k++) step();
        check("t3_pending_addr", imem_req_addr, 32'h0000_0008);
        imem_req_ready = 1'b0;
        repeat (2) step();
        jump_flag = 1'b1; jump_target = 32'h0000_0103;
        step();
        jump_flag = 1'b0;
        got.delete(); got_d.delete();
        check("t3_inst_valid_after_jump", 32'(inst_valid), 32'h0);
        check("t3_hold_valid", 32'(imem_req_valid), 32'h1);
        check("t3_hold_addr", imem_req_addr, 32'h0000_0008);
        repeat (2) step();
        check("t3_hold_addr_later", imem_req_addr, 32'h0000_0008);
        imem_req_ready = 1'b1;
        step();
        check("t3_next_req_addr", imem_req_addr, 32'h0000_0100);
        repeat (8) step();
        check("t3_pc0", (got.size() > 0) ? got[0] : 32'hDEAD_BEEF, 32'h0000_0100);
        check("t3_pc1", (got.size() > 1) ? got[1] : 32'hDEAD_BEEF, 32'h0000_0104);

        // Redirect with three responses outstanding at latency 3
        do_reset();
        lat = 3; imem_req_ready = 1'b1; inst_ready = 1'b1; hs_count = 0;
        reset = 1'b1;
        for (int k = 0; k < 10 && hs_count < 3; k++) step();
        check("t4_inflight", 32'(hs_count), 32'd3);
        jump_flag = 1'b1; jump_target = 32'h0000_0040;
        step();
        jump_flag = 1'b0;
        got.delete(); got_d.delete();
        check("t4_inst_valid_after_jump", 32'(inst_valid), 32'h0);
        repeat (12) step();
        check("t4_pc0", (got.size() > 0) ? got[0] : 32'hDEAD_BEEF, 32'h0000_0040);
        check("t4_pc1", (got.size() > 1) ? got[1] : 32'hDEAD_BEEF, 32'h0000_0044);
        check("t4_word0", (got_d.size() > 0) ? got_d[0] : 32'hDEAD_BEEF, enc(32'h0000_0040));

        // Asynchronous reset mid-stream
        do_reset();
        lat = 2; imem_req_ready = 1'b1; inst_ready = 1'b0; hs_count = 0;
        reset = 1'b1;
        for (int k = 0; k < 12 && hs_count < 4; k++) step();
        check("t6_fifo_nonempty", 32'(inst_valid), 32'h1);
        reset = 1'b0;
        #1;
        check("t6_req_valid", 32'(imem_req_valid), 32'h0);
        check("t6_req_addr", imem_req_addr, 32'h0000_0000);
        check("t6_inst_valid", 32'(inst_valid), 32'h0);
        check("t6_inst", inst, 32'h0000_0013);
        check("t6_inst_pc", inst_pc, 32'h0000_0000);
        clear_models();
        repeat (2) step();
        clear_models();
        lat = 1; inst_ready = 1'b1;
        reset = 1'b1;
        step();
        check("t6_restart_valid", 32'(imem_req_valid), 32'h1);
        check("t6_restart_addr", imem_req_addr, 32'h0000_0000);
        repeat (6) step();
        check("t6_pc0", (got.size() > 0) ? got[0] : 32'hDEAD_BEEF, 32'h0000_0000);
        check("t6_pc1", (got.size() > 1) ? got[1] : 32'hDEAD_BEEF, 32'h0000_0004);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
